// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Purpose: holds the PC, issues word fetches over a req/ready handshake and
// latches each returned instruction with PC+4 into IF/ID. A one-entry skid
// buffer catches a response that arrives while decode is stalled. Branch
// redirects and flushes kill the IF/ID contents.
//
// Optional feature: define FETCH_TIMEOUT_EN to build the wait-state counter
// that raises the sticky fetch_fault flag after TIMEOUT_CYCLES unanswered
// request cycles. Without it fetch_fault is constant 0.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_req/imem_addr         fetch request and word-aligned address
//   imem_ready/imem_rdata      response strobe and instruction word
//   stall, flush               decode back-pressure and IF/ID kill
//   branch_taken/branch_target redirect request and address
//   if_id_valid/instr/pc_plus4 IF/ID register contents
//   if_id_imm                  if_id_instr[15:0] for the sign extender
//   fetch_fault                sticky fetch timeout flag
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [15:0] if_id_imm,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] pc_plus4;

    // Target low bits are forced to zero; they are intentionally ignored.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^branch_target[1:0];

    // Wraps modulo 2^32 with no flag.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        imem_req     = (state_q == ST_FETCH);
        imem_addr    = pc_q;

        if (branch_taken) begin
            // Any outstanding response is dropped, even if ready this cycle.
            pc_d    = {branch_target[31:2], 2'b00};
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_FETCH;
                    if (flush) valid_d = 1'b0;
                end
                ST_FETCH: begin
                    if (flush) begin
                        // PC is not advanced, so a response arriving now is
                        // simply fetched again next cycle.
                        valid_d = 1'b0;
                    end else if (imem_ready && !stall) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end else if (imem_ready) begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = ST_HOLD;
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        // Skid contents discarded; refetch the same PC.
                        valid_d = 1'b0;
                        state_d = ST_FETCH;
                    end else if (!stall) begin
                        instr_d = skid_instr_q;
                        pc4_d   = skid_pc4_q;
                        valid_d = 1'b1;
                        pc_d    = skid_pc4_q;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_imm      = instr_q[15:0];

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        fault_q, fault_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (branch_taken || imem_ready) begin
            wait_cnt_d = 16'h0;
        end else if (state_q == ST_FETCH && wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
        fault_d = fault_q | (wait_cnt_d == 16'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 16'h0;
            fault_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    // No counter built; the parameter is referenced only so both builds
    // share one parameter list.
    assign fetch_fault = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - table-driven self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic [15:0] if_id_imm;
    logic        fetch_fault;

    int checks;
    int failures;

    instr_fetch_stage #(
        .RESET_PC      (32'h0040_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_imm     (if_id_imm),
        .fetch_fault   (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] tgt;
        logic        ready;
        logic [31:0] rdata;
        logic        ereq;     // before the edge
        logic [31:0] eaddr;    // before the edge
        logic        evalid;   // after the edge
        logic [31:0] einstr;   // after the edge
        logic [31:0] epc4;     // after the edge
    } vec_t;

    vec_t vec[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall = 1'b0;
        flush = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;

        //          stall flush br  tgt           rdy   rdata         req   addr          vld   instr         pc4
        vec[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0000, 1'b0, 32'h0,        32'h0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2008_BEEF, 1'b1, 32'h0040_0000, 1'b1, 32'h2008_BEEF, 32'h0040_0004};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2009_DEAD, 1'b1, 32'h0040_0004, 1'b1, 32'h2009_DEAD, 32'h0040_0008};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3C0A_7FFF, 1'b1, 32'h0040_0008, 1'b1, 32'h2009_DEAD, 32'h0040_0008};
        vec[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0008, 1'b1, 32'h2009_DEAD, 32'h0040_0008};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0008, 1'b1, 32'h2009_DEAD, 32'h0040_0008};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0008, 1'b1, 32'h3C0A_7FFF, 32'h0040_000C};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0040_000C, 1'b0, 32'h3C0A_7FFF, 32'h0040_000C};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0001, 1'b1, 32'h0040_000C, 1'b1, 32'h0000_0001, 32'h0040_0010};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0040_0010, 1'b0, 32'h0000_0001, 32'h0040_0010};
        vec[10] = '{1'b0, 1'b0, 1'b1, 32'h0040_0103, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'h0040_0010, 1'b0, 32'h0000_0001, 32'h0040_0010};
        vec[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0040_0100, 1'b0, 32'h0000_0001, 32'h0040_0010};
        vec[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1111_2222, 1'b1, 32'h0040_0100, 1'b1, 32'h1111_2222, 32'h0040_0104};
        vec[13] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b1, 32'h0040_0104, 1'b0, 32'h1111_2222, 32'h0040_0104};
        vec[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8C08_0004, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h8C08_0004, 32'h0000_0000};
        vec[15] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h8C08_0004, 32'h0000_0000};
        vec[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h8C08_0004, 32'h0000_0000};
        vec[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2442_0001, 1'b1, 32'h0000_0000, 1'b1, 32'h2442_0001, 32'h0000_0004};
        vec[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h5555_6666, 1'b1, 32'h0000_0004, 1'b1, 32'h2442_0001, 32'h0000_0004};
        vec[19] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b0, 32'h2442_0001, 32'h0000_0004};
        vec[20] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h7777_8888, 1'b1, 32'h0000_0004, 1'b1, 32'h7777_8888, 32'h0000_0008};

        // Reset state
        tick();
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            stall         = vec[i].stall;
            flush         = vec[i].flush;
            branch_taken  = vec[i].br;
            branch_target = vec[i].tgt;
            imem_ready    = vec[i].ready;
            imem_rdata    = vec[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vec[i].ereq});
            chk($sformatf("v%0d_addr", i), imem_addr, vec[i].eaddr);
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vec[i].evalid});
            chk($sformatf("v%0d_instr", i), if_id_instr, vec[i].einstr);
            chk($sformatf("v%0d_pc4", i), if_id_pc_plus4, vec[i].epc4);
            chk($sformatf("v%0d_imm", i), {16'b0, if_id_imm}, {16'b0, vec[i].einstr[15:0]});
            chk($sformatf("v%0d_fault", i), {31'b0, fetch_fault}, 32'h0);
        end

        // Reset asserted mid-request clears state immediately
        stall = 1'b0;
        flush = 1'b0;
        branch_taken = 1'b0;
        imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        chk("midrst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("midrst_instr", if_id_instr, 32'h0);
        chk("midrst_pc4", if_id_pc_plus4, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("boot_req", {31'b0, imem_req}, 32'h0);
        tick();
        for (int k = 0; k < 4 && !imem_req; k++) tick();
        chk("reboot_req", {31'b0, imem_req}, 32'h1);
        chk("reboot_addr", imem_addr, 32'h0040_0000);

`ifdef FETCH_TIMEOUT_EN
        // Fresh reset, then four unanswered FETCH cycles
        rst_n = 1'b0;
        #1;
        chk("to_rst_fault", {31'b0, fetch_fault}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();  // BOOT -> FETCH
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("to_fault_c%0d", k), {31'b0, fetch_fault}, (k >= 4) ? 32'h1 : 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_1234;
        tick();
        chk("to_sticky", {31'b0, fetch_fault}, 32'h1);
        imem_ready = 1'b0;
        tick();
        chk("to_sticky2", {31'b0, fetch_fault}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("to_cleared", {31'b0, fetch_fault}, 32'h0);
        tick();
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS core.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Latches each returned instruction with PC+4 into the IF/ID register.
- Exposes the raw 16-bit immediate field, which the decode-stage sign extender consumes directly.
- Handles decode stalls, pipeline flushes and branch redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, wait-state limit before fetch_fault; used only with FETCH_TIMEOUT_EN

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address
imem_ready  input  1  imem_rdata valid this cycle; completes the request
imem_rdata  input  32  fetched instruction
stall  input  1  decode cannot accept; IF/ID must hold
flush  input  1  kill IF/ID contents (bubble)
branch_taken  input  1  redirect PC; implies flush
branch_target  input  32  redirect address; bits [1:0] ignored
if_id_valid  output  1  IF/ID holds a live instruction
if_id_instr  output  32  latched instruction
if_id_pc_plus4  output  32  PC of latched instruction + 4
if_id_imm  output  16  if_id_instr[15:0], combinational tap for sign extension
fetch_fault  output  1  sticky timeout flag; tied 0 without FETCH_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - imem_req=0; if_id_valid=0, if_id_instr=0, if_id_pc_plus4=0; fetch_fault=0; skid buffer cleared.
- State BOOT: imem_req=0 for exactly one cycle after reset release, then go to FETCH.
- State FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=0: request stays pending; imem_addr stays stable.
    - IF/ID holds if stall=1.
    - Otherwise if_id_valid<=0 (bubble).
  - imem_ready=1, stall=0:
    - if_id_instr<=imem_rdata, if_id_pc_plus4<=pc+4, if_id_valid<=1.
    - pc<=pc+4; stay in FETCH.
    - Back-to-back fetches give one instruction per cycle.
  - imem_ready=1, stall=1:
    - Capture rdata and pc+4 into the skid buffer; go to HOLD.
    - IF/ID unchanged; pc is not advanced yet.
- State HOLD: imem_req=0; IF/ID and skid buffer hold while stall=1.
  - On the first cycle with stall=0, the skid buffer moves to IF/ID (valid=1), pc<=pc+4, and the state returns to FETCH.
  - Next imem_req is therefore asserted one cycle after stall deasserts.
- Redirect (branch_taken=1), highest priority, any state:
  - pc<={branch_target[31:2],2'b00}; if_id_valid<=0; skid buffer discarded; state<=FETCH.
  - Any outstanding request is abandoned, even if imem_ready=1 that cycle; its data is dropped.
  - imem_addr shows the new target on the next cycle. Instruction memory tolerates abandoned requests.
- Flush alone (flush=1, branch_taken=0):
  - if_id_valid<=0 and skid buffer discarded.
  - pc and any pending request unaffected; a HOLD state returns to FETCH re-fetching the same pc.
  - flush overrides stall for the IF/ID register.
- Priority: rst_n > branch_taken > flush > stall > imem_ready.
- Arithmetic:
  - pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000, with no flag.
  - pc[1:0] is always 00.
- if_id_instr and if_id_pc_plus4 retain stale values when if_id_valid=0; consumers qualify on valid.
- Reset asserted mid-request: all state is cleared immediately; the next request is issued to RESET_PC after BOOT.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter increments each FETCH cycle with imem_req=1 and imem_ready=0.
  - It clears on imem_ready, redirect or reset.
  - When the counter reaches TIMEOUT_CYCLES, fetch_fault<=1. The flag is sticky until reset.
  - The fetch stays pending; no other behaviour changes.
- Undefined: no counter is built and fetch_fault is constant 0.

Test Plan:
- Reset/boot: RESET_PC=32'h0040_0000, release rst_n -> imem_req=0 for 1 cycle, then imem_req=1 with imem_addr=32'h0040_0000; all IF/ID outputs 0.
- Streaming: imem_ready=1 every cycle, rdata=32'h2008BEEF then 32'h2009DEAD -> if_id_valid=1 and if_id_imm=16'hBEEF, pc_plus4=32'h0040_0004; next cycle if_id_imm=16'hDEAD, pc_plus4=32'h0040_0008.
- Stall with skid: stall=1 on a ready cycle with rdata=32'h3C0A7FFF for 3 cycles -> IF/ID unchanged and imem_req=0 during HOLD; after stall drops, if_id_instr=32'h3C0A7FFF next cycle and no instruction is lost or duplicated.
- Branch during wait: request pending at 32'h0040_0010, branch_taken=1 with target 32'h0040_0103 -> if_id_valid=0 and next imem_addr=32'h0040_0100; a late imem_ready for the old address is ignored.
- Wrap and flush: pc=32'hFFFF_FFFC fetched -> if_id_pc_plus4=0 and next imem_addr=0; then flush=1 with stall=1 -> if_id_valid=0 while pc is held.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4: hold imem_ready=0 for 4 cycles -> fetch_fault=1 and stays 1 after ready returns, until rst_n=0.
